// File: rtl/rv_isa_pkg.sv
// -----------------------------------------------------------------------------
// rv_isa_pkg
// Shared RV32I definitions: major opcode constants, the instruction format
// enumeration used by the encoder, the canonical NOP word, and two helpers
// that classify an opcode into a format and test whether an immediate can be
// represented in that format.
// -----------------------------------------------------------------------------
package rv_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_SHI = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

  // Map a major opcode (plus funct3 for the OP-IMM shift split) to a format.
  function automatic fmt_e classify(input logic [6:0] opcode,
                                    input logic [2:0] funct3);
    fmt_e f;
    f = FMT_BAD;
    case (opcode)
      OPC_LOAD, OPC_JALR: f = FMT_I;
      OPC_OPIMM: begin
        // slli / srli / srai carry a 5-bit shamt instead of a 12-bit imm
        if (funct3 == 3'b001 || funct3 == 3'b101) f = FMT_SHI;
        else                                      f = FMT_I;
      end
      OPC_STORE:           f = FMT_S;
      OPC_BRANCH:          f = FMT_B;
      OPC_JAL:             f = FMT_J;
      OPC_LUI, OPC_AUIPC:  f = FMT_U;
      OPC_OP:              f = FMT_R;
      default:             f = FMT_BAD;
    endcase
    return f;
  endfunction

  // True when imm survives the round trip through the selected format.
  // Sign-extended formats require the discarded upper bits to all equal the
  // format's sign bit; branch/jump offsets must also be halfword aligned.
  function automatic logic imm_fits(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FMT_R:        ok = 1'b1;
      FMT_I, FMT_S: ok = (&imm[31:11]) || ~(|imm[31:11]);
      FMT_SHI:      ok = ~(|imm[31:5]);
      FMT_B:        ok = ((&imm[31:12]) || ~(|imm[31:12])) && !imm[0];
      FMT_J:        ok = ((&imm[31:20]) || ~(|imm[31:20])) && !imm[0];
      FMT_U:        ok = ~(|imm[11:0]);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational RV32I field packer: scatters the immediate and register
// fields into the standard bit positions of the selected format.
//
// Ports:
//   fmt_i     format selector (FMT_BAD yields the NOP word)
//   opcode_i  major opcode, copied to inst_o[6:0]
//   funct3_i  funct3 field
//   funct7_i  funct7 field (R-type and OP-IMM shifts only)
//   rd_i, rs1_i, rs2_i  register indices
//   imm_i     immediate, byte-offset semantics
//   inst_o    packed instruction word
// -----------------------------------------------------------------------------
module inst_pack
  import rv_isa_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o
);

  always_comb begin
    inst_o = INST_NOP;
    case (fmt_i)
      FMT_R:   inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I:   inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_SHI: inst_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S:   inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B:   inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
      FMT_U:   inst_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J:   inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                         rd_i, opcode_i};
      default: inst_o = INST_NOP;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Two-stage pipelined RV32I instruction encoder. Stage 1 captures the decoded
// fields, classifies the format and performs the immediate range check.
// Stage 2 holds the packed word and its error flag. Unrepresentable
// immediates and unknown opcodes produce a NOP with err=1, and every
// delivered err word bumps a saturating counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds its payload until it transfers; ready may depend on the
// downstream ready but never on the same side's valid.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   in_valid/in_ready input handshake
//   opcode, funct3, funct7, rd, rs1, rs2, imm   decoded fields
//   out_valid/out_ready output handshake
//   inst, err         packed word and error flag
//   err_count         saturating count of delivered err words
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  import rv_isa_pkg::*;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q,   s1_fmt_d;
  logic        s1_err_q,   s1_err_d;
  logic [6:0]  s1_opcode_q, s1_opcode_d;
  logic [2:0]  s1_funct3_q, s1_funct3_d;
  logic [6:0]  s1_funct7_q, s1_funct7_d;
  logic [4:0]  s1_rd_q,  s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [31:0] s1_imm_q, s1_imm_d;

  // ---------------------------------------------------------------------------
  // Stage 2 registers
  // ---------------------------------------------------------------------------
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          inst_q,      inst_d;
  logic                 err_q,       err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic  s2_free;   // stage 2 is empty or emptying this cycle
  logic  in_fire;
  logic  out_fire;
  fmt_e  in_fmt;
  logic  in_err;
  logic [31:0] packed_inst;

  assign s2_free  = !out_valid_q || out_ready;
  // Stage 1 is free if empty, or if its word moves into stage 2 this edge.
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Classification and range check happen on the incoming fields so the
  // stage-2 path is only the packer plus the NOP substitution mux.
  assign in_fmt = classify(opcode, funct3);
  assign in_err = (in_fmt == FMT_BAD) || !imm_fits(in_fmt, imm);

  inst_pack u_pack (
    .fmt_i    (s1_fmt_q),
    .opcode_i (s1_opcode_q),
    .funct3_i (s1_funct3_q),
    .funct7_i (s1_funct7_q),
    .rd_i     (s1_rd_q),
    .rs1_i    (s1_rs1_q),
    .rs2_i    (s1_rs2_q),
    .imm_i    (s1_imm_q),
    .inst_o   (packed_inst)
  );

  // ---------------------------------------------------------------------------
  // Stage 1 next state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fmt_d    = s1_fmt_q;
    s1_err_d    = s1_err_q;
    s1_opcode_d = s1_opcode_q;
    s1_funct3_d = s1_funct3_q;
    s1_funct7_d = s1_funct7_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_imm_d    = s1_imm_q;

    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_fmt_d    = in_fmt;
      s1_err_d    = in_err;
      s1_opcode_d = opcode;
      s1_funct3_d = funct3;
      s1_funct7_d = funct7;
      s1_rd_d     = rd;
      s1_rs1_d    = rs1;
      s1_rs2_d    = rs2;
      s1_imm_d    = imm;
    end else if (s2_free) begin
      // Whatever stage 1 held has moved on (or it was already empty).
      s1_valid_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 next state and error counter
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    if (s2_free) begin
      out_valid_d = s1_valid_q;
      // Payload only changes when a real word arrives, so an idle output
      // keeps showing the last delivered word.
      if (s1_valid_q) begin
        inst_d = s1_err_q ? INST_NOP : packed_inst;
        err_d  = s1_err_q;
      end
    end

    if (out_fire && err_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_R;
      s1_err_q    <= 1'b0;
      s1_opcode_q <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_imm_q    <= '0;
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_err_q    <= s1_err_d;
      s1_opcode_q <= s1_opcode_d;
      s1_funct3_q <= s1_funct3_d;
      s1_funct7_q <= s1_funct7_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_imm_q    <= s1_imm_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign inst      = inst_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Directed self-checking bench for inst_encoder. Expected {err, inst} words
// are pushed when an input transfer is seen and popped by a monitor when the
// encoder delivers a word. The error counter is narrowed to 3 bits so that
// saturation is reached with a handful of bad words.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic          in_valid, in_ready;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          out_valid, out_ready;
  logic [31:0]   inst;
  logic          err;
  logic [CW-1:0] err_count;

  inst_encoder #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .err       (err),
    .err_count (err_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [32:0]   exp_q[$];
  int            pop_cyc_q[$];
  int            acc_cyc;
  logic [CW-1:0] exp_cnt;
  logic          stall_seen;
  logic [32:0]   stall_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: ranges expressed as signed intervals, fields placed by
  // the RV32I layout.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [31:0] im);
    logic [31:0] w;
    logic        bad;
    longint      v;
    v   = longint'($signed(im));
    w   = 32'h0;
    bad = 1'b0;
    case (op)
      7'b0000011, 7'b1100111, 7'b0010011: begin
        if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
          bad = (im > 32'd31);
          w   = {f7, im[4:0], s1, f3, d, op};
        end else begin
          bad = (v < -2048) || (v > 2047);
          w   = {im[11:0], s1, f3, d, op};
        end
      end
      7'b0100011: begin
        bad = (v < -2048) || (v > 2047);
        w   = {im[11:5], s2, s1, f3, im[4:0], op};
      end
      7'b1100011: begin
        bad = (v < -4096) || (v > 4095) || im[0];
        w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      end
      7'b1101111: begin
        bad = (v < -1048576) || (v > 1048575) || im[0];
        w   = {im[20], im[10:1], im[11], im[19:12], d, op};
      end
      7'b0110111, 7'b0010111: begin
        bad = (im[11:0] != 12'h0);
        w   = {im[31:12], d, op};
      end
      7'b0110011: w = {f7, s2, s1, f3, d, op};
      default:    bad = 1'b1;
    endcase
    if (bad) w = 32'h0000_0013;
    return {bad, w};
  endfunction

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("err_count", 64'(err_count), 64'(exp_cnt));
      if (out_valid && !out_ready) begin
        if (stall_seen) chk("stall_stable", 64'({err, inst}), 64'(stall_word));
        stall_seen = 1'b1;
        stall_word = {err, inst};
      end else begin
        stall_seen = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_word: got %0h expected none", {err, inst});
        end
        if (exp_q.size() != 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("word", 64'({err, inst}), 64'(e));
          pop_cyc_q.push_back(cyc);
          if (e[32] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
        end
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [32:0] e);
    int n;
    n = 0;
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (in_ready) else begin
      errors++;
      $error("FAIL send_timeout: got in_ready=%0b expected 1", in_ready);
    end
    if (in_ready) begin
      exp_q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
    send(op, f3, f7, d, s1, s2, im, model(op, f3, f7, d, s1, s2, im));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [6:0] op_tab [6];
  initial begin
    op_tab[0] = 7'b0000011; op_tab[1] = 7'b0010011; op_tab[2] = 7'b0100011;
    op_tab[3] = 7'b1100011; op_tab[4] = 7'b1101111; op_tab[5] = 7'b0110111;
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    exp_cnt   = '0;
    stall_seen = 1'b0;
    stall_word = '0;
    acc_cyc   = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed encodings with hand-computed words
    pop_cyc_q.delete();
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, {1'b0, 32'hFFF0_0093});
    begin
      int a0;
      a0 = acc_cyc;
      send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h8, {1'b0, 32'h0020_8463});
      send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, {1'b0, 32'h0010_00EF});
      send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, {1'b0, 32'h1234_52B7});
      send(7'b0010011, 3'd5, 7'b0100000, 5'd3, 5'd4, 5'd0, 32'd5, {1'b0, 32'h4052_5193});
      drain();
      chk("latency", 64'(pop_cyc_q[0] - a0), 64'd2);
    end
    chk("no_err_count", 64'(err_count), 64'd0);

    // Errors: misaligned branch, I-type out of range, unknown opcode
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, {1'b1, 32'h0000_0013});
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048, {1'b1, 32'h0000_0013});
    send(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, {1'b1, 32'h0000_0013});
    drain();
    chk("err_count_3", 64'(err_count), 64'd3);

    // Boundary values and more errors, pushing the counter into saturation
    send(7'b0010011, 3'd5, 7'b0100000, 5'd3, 5'd4, 5'd0, 32'd32, {1'b1, 32'h0000_0013});
    send_m(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
    send_m(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'h0000_1000);
    send_m(7'b1100011, 3'd1, 7'd0, 5'd0, 5'd6, 5'd7, 32'hFFFF_F000);
    send_m(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000);
    send_m(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0011);
    send_m(7'b0010111, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCD_E000);
    send_m(7'b0110111, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'h0000_0123);
    send_m(7'b0010011, 3'd1, 7'd0, 5'd8, 5'd8, 5'd0, 32'hFFFF_FFFF);
    send_m(7'b0110011, 3'd0, 7'b0100000, 5'd10, 5'd11, 5'd12, 32'hDEAD_BEEF);
    send_m(7'b1100111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2047);
    send_m(7'b0000011, 3'd2, 7'd0, 5'd4, 5'd5, 5'd0, 32'hFFFF_F800);
    send_m(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom_range(32'h0000_1FFF, 0);
      if ($urandom_range(1, 0) == 1) r = ~r;
      send_m(op_tab[$urandom_range(5, 0)], 3'($urandom_range(7, 0)), 7'd0,
             5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
             5'($urandom_range(31, 0)), r);
    end
    drain();
    chk("err_count_sat", 64'(err_count), 64'(CNT_MAX));

    // Backpressure: two words fill the pipe while the consumer stalls
    out_ready = 1'b0;
    pop_cyc_q.delete();
    send_m(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1);
    send_m(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd2);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_m(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd3, 5'd0, 32'd3);
    send_m(7'b0010011, 3'd0, 7'd0, 5'd4, 5'd4, 5'd0, 32'd4);
    drain();
    chk("bp_count", 64'(pop_cyc_q.size()), 64'd4);
    if (pop_cyc_q.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("bp_full_rate", 64'(pop_cyc_q[i+1] - pop_cyc_q[i]), 64'd1);
    end

    // Reset with two words in flight
    out_ready = 1'b0;
    send_m(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    send_m(7'b0110011, 3'd7, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    chk("mid_rst_inst", 64'(inst), 64'd0);
    exp_cnt = '0;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("no_stale_word", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, {1'b0, 32'hFFF0_0093});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
